modexp_wb: RTL and testbench

- Parametrised Wishbone-slave modular exponentiation accelerator; successor to the fixed-width 128-bit modexp peripheral.
- Computes RESULT = BASE^EXP mod MOD.
- Operand width scales to RSA sizes (1024 bits) behind a narrow word-addressed bus.
- Adds abort, error reporting, a busy flag and an interrupt output.

---
 rtl/modexp_wb.sv | 224 ++++++++++++++++++++++
 tb/tb_modexp_wb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/modexp_wb.sv
// Wishbone-slave modular exponentiation engine: RESULT = BASE^EXP mod MOD using
// right-to-left square-and-multiply over an interleaved, bit-serial modular multiplier.
module modexp_wb #(
   parameter int WIDTH = 128,
   parameter int DW    = 32,
   localparam int NW   = WIDTH / DW,
   localparam int AW   = 3 + $clog2(NW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   input  logic          we,
   input  logic          stb,
   input  logic          cyc,
   output logic          ack,
   output logic          irq
);
   localparam int IW = $clog2(NW);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, PRE, CHECK, MUL, SQR, FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d, result_q, result_d;
   logic [WIDTH-1:0] b_q, b_d, e_q, e_d, r_q, r_d, ma_q, ma_d, mb_q, mb_d;
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             prime_q, prime_d, done_q, done_d, err_q, err_d;
   logic             irqEn_q, irqEn_d, ack_q, ack_d;
   logic [DW-1:0]    dout_q, dout_d, rdata;
   logic [2:0]       sel;
   logic [IW-1:0]    idx;
   logic             accept, wr, ctrlWr, busy, lastStep, stepping;
   logic [WIDTH+1:0] modX, sum, red1, red2;

   assign sel      = addr[AW-1:AW-3];
   assign idx      = addr[IW-1:0];
   assign accept   = stb & cyc & ~ack_q;
   assign wr       = accept & we;
   assign ctrlWr   = wr && (sel == 3'd3) && (idx == '0);
   assign busy     = (state_q != IDLE);
   assign ack      = ack_q;
   assign data_out = dout_q;
   assign irq      = done_q & irqEn_q;

   // One multiplier bit per cycle, MSB first; acc stays below MOD after two subtractions.
   assign modX     = {2'b00, mod_q};
   assign sum      = (acc_q << 1) + (ma_q[WIDTH-1] ? {2'b00, mb_q} : '0);
   assign red1     = (sum >= modX) ? sum - modX : sum;
   assign red2     = (red1 >= modX) ? red1 - modX : red1;
   assign lastStep = (cnt_q == CW'(WIDTH - 1));
   assign stepping = ((state_q == PRE) && !prime_q) || (state_q == MUL) || (state_q == SQR);

   always_comb begin
      rdata = '0;
      case (sel)
         3'd0: rdata = base_q[idx*DW +: DW];
         3'd1: rdata = exp_q[idx*DW +: DW];
         3'd2: rdata = mod_q[idx*DW +: DW];
         3'd3: if (idx == '0) rdata = DW'({irqEn_q, 2'b00});
         3'd4: rdata = result_q[idx*DW +: DW];
         3'd5: if (idx == '0) rdata = DW'({err_q, busy, done_q});
         default: rdata = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      exp_d    = exp_q;
      mod_d    = mod_q;
      result_d = result_q;
      b_d      = b_q;
      e_d      = e_q;
      r_d      = r_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prime_d  = prime_q;
      done_d   = done_q;
      err_d    = err_q;
      irqEn_d  = irqEn_q;
      ack_d    = accept;
      dout_d   = accept ? rdata : '0;

      if (wr) begin
         case (sel)
            3'd0: if (!busy) base_d[idx*DW +: DW] = data_in;
            3'd1: if (!busy) exp_d[idx*DW +: DW] = data_in;
            3'd2: if (!busy) mod_d[idx*DW +: DW] = data_in;
            3'd3: if (idx == '0) irqEn_d = data_in[2];
            3'd5: if ((idx == '0) && data_in[0]) done_d = 1'b0;
            default: ;
         endcase
      end

      if (stepping) begin
         acc_d = red2;
         ma_d  = ma_q << 1;
         cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (ctrlWr && data_in[0] && !data_in[1]) begin
               state_d = PRE;
               done_d  = 1'b0;
               err_d   = 1'b0;
               b_d     = base_q;
               e_d     = exp_q;
               r_d     = WIDTH'(1);
               prime_d = 1'b1;
            end
         end
         PRE: begin
            // The first PRE cycle screens out MOD==0 and loads the b*1 reduction.
            if (prime_q) begin
               if (mod_q == '0) begin
                  state_d = FIN;
               end else begin
                  prime_d = 1'b0;
                  ma_d    = b_q;
                  mb_d    = WIDTH'(1);
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end else if (lastStep) begin
               b_d     = red2[WIDTH-1:0];
               state_d = CHECK;
            end
         end
         CHECK: begin
            acc_d = '0;
            cnt_d = '0;
            if (e_q == '0) begin
               state_d = FIN;
            end else if (e_q[0]) begin
               state_d = MUL;
               ma_d    = r_q;
               mb_d    = b_q;
            end else begin
               state_d = SQR;
               ma_d    = b_q;
               mb_d    = b_q;
            end
         end
         MUL: begin
            if (lastStep) begin
               r_d     = red2[WIDTH-1:0];
               state_d = SQR;
               ma_d    = b_q;
               mb_d    = b_q;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         SQR: begin
            if (lastStep) begin
               b_d     = red2[WIDTH-1:0];
               e_d     = e_q >> 1;
               state_d = CHECK;
            end
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (mod_q == '0) err_d = 1'b1;
            else result_d = (mod_q == WIDTH'(1)) ? '0 : r_q;
         end
         default: state_d = IDLE;
      endcase

      if (ctrlWr && data_in[1] && busy) begin
         state_d = IDLE;
         done_d  = 1'b0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         exp_q    <= '0;
         mod_q    <= '0;
         result_q <= '0;
         b_q      <= '0;
         e_q      <= '0;
         r_q      <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prime_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irqEn_q  <= 1'b0;
         ack_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         mod_q    <= mod_d;
         result_q <= result_d;
         b_q      <= b_d;
         e_q      <= e_d;
         r_q      <= r_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prime_q  <= prime_d;
         done_q   <= done_d;
         err_q    <= err_d;
         irqEn_q  <= irqEn_d;
         ack_q    <= ack_d;
         dout_q   <= dout_d;
      end
   end
endmodule

// File: tb/tb_modexp_wb.sv
// Self-checking bench for modexp_wb: directed and random exponentiations compared
// against a plain-arithmetic square-and-multiply model, plus bus/control corner cases.
module tb_modexp_wb;
   localparam int WIDTH = 128;
   localparam int DW    = 32;
   localparam int NW    = WIDTH / DW;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in, data_out;
   logic          we, stb, cyc, ack, irq;

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] lastResult = '0;

   modexp_wb #(.WIDTH(WIDTH), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out),
      .we(we), .stb(stb), .cyc(cyc), .ack(ack), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic busWrite(input logic [2:0] sel, input int idx, input logic [DW-1:0] d);
      @(negedge clk);
      addr = {sel, 2'(idx)}; data_in = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      @(negedge clk);
      we = 1'b0; stb = 1'b0; cyc = 1'b0;
   endtask

   task automatic busRead(input logic [2:0] sel, input int idx, output logic [DW-1:0] d);
      @(negedge clk);
      addr = {sel, 2'(idx)}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      @(negedge clk);
      checkOutput("ack", WIDTH'(ack), WIDTH'(1));
      d = data_out;
      stb = 1'b0; cyc = 1'b0;
   endtask

   task automatic writeWide(input logic [2:0] sel, input logic [WIDTH-1:0] v);
      for (int w = 0; w < NW; w++) busWrite(sel, w, v[w*DW +: DW]);
   endtask

   task automatic readWide(input logic [2:0] sel, output logic [WIDTH-1:0] v);
      logic [DW-1:0] d;
      for (int w = 0; w < NW; w++) begin
         busRead(sel, w, d);
         v[w*DW +: DW] = d;
      end
   endtask

   function automatic logic [WIDTH-1:0] refModExp(input logic [WIDTH-1:0] b, e, m);
      logic [2*WIDTH-1:0] r, x, mm;
      logic [WIDTH-1:0]   ee;
      mm = {{WIDTH{1'b0}}, m};
      x  = {{WIDTH{1'b0}}, b} % mm;
      r  = 1;
      r  = r % mm;
      ee = e;
      while (ee != 0) begin
         if (ee[0]) r = (r * x) % mm;
         x  = (x * x) % mm;
         ee = ee >> 1;
      end
      return r[WIDTH-1:0];
   endfunction

   function automatic int expLatency(input logic [WIDTH-1:0] e, m);
      int lat, msb;
      if (m == 0) return 2;
      lat = WIDTH + 3;
      msb = -1;
      for (int i = 0; i < WIDTH; i++) if (e[i]) msb = i;
      for (int i = 0; i <= msb; i++) lat += 1 + WIDTH * (1 + int'(e[i]));
      return lat;
   endfunction

   task automatic applyStimulus(input logic [WIDTH-1:0] b, e, m);
      writeWide(3'd0, b);
      writeWide(3'd1, e);
      writeWide(3'd2, m);
      busWrite(3'd3, 0, 32'h5);
   endtask

   task automatic waitIrq(output int n);
      n = 0;
      while (irq !== 1'b1 && n < 50000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic checkEnd(input string tag, input logic isErr, input logic [WIDTH-1:0] expRes);
      logic [DW-1:0]    st;
      logic [WIDTH-1:0] v;
      busRead(3'd5, 0, st);
      checkOutput({tag, " status"}, WIDTH'(st), isErr ? WIDTH'(5) : WIDTH'(1));
      readWide(3'd4, v);
      checkOutput({tag, " result"}, v, expRes);
      lastResult = expRes;
   endtask

   task automatic runOp(input string tag, input logic [WIDTH-1:0] b, e, m, expRes);
      int n;
      applyStimulus(b, e, m);
      waitIrq(n);
      checkOutput({tag, " latency"}, WIDTH'(n), WIDTH'(expLatency(e, m)));
      checkEnd(tag, (m == 0), expRes);
   endtask

   initial begin
      logic [WIDTH-1:0] b, e, m, v;
      logic [DW-1:0]    st;
      int               n;

      rst_n = 1'b0; addr = '0; data_in = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset ack", WIDTH'(ack), '0);
      checkOutput("reset irq", WIDTH'(irq), '0);
      checkOutput("reset data_out", WIDTH'(data_out), '0);
      rst_n = 1'b1;
      readWide(3'd4, v);
      checkOutput("reset result", v, '0);
      readWide(3'd0, v);
      checkOutput("reset base", v, '0);
      busRead(3'd5, 0, st);
      checkOutput("reset status", WIDTH'(st), '0);
      @(negedge clk);
      checkOutput("ack single cycle", WIDTH'(ack), '0);

      busWrite(3'd6, 0, 32'hFFFF_FFFF);
      busRead(3'd6, 0, st);
      checkOutput("reg6 reads 0", WIDTH'(st), '0);
      busWrite(3'd3, 0, 32'h4);
      busRead(3'd3, 0, st);
      checkOutput("ctrl irq_en", WIDTH'(st), WIDTH'(4));

      runOp("p1", WIDTH'(4), WIDTH'(13), WIDTH'(497), WIDTH'(445));
      runOp("p2", WIDTH'(5), WIDTH'(117), WIDTH'(19), WIDTH'(1));
      runOp("p3", WIDTH'(7), WIDTH'(256), WIDTH'(13), WIDTH'(9));
      b = '0; b[100] = 1'b1;
      m = {1'b0, {(WIDTH-1){1'b1}}};
      v = '0; v[73] = 1'b1;
      runOp("multiword", b, WIDTH'(2), m, v);
      runOp("mod0", WIDTH'(4), WIDTH'(13), '0, lastResult);
      runOp("exp0", WIDTH'(4), '0, WIDTH'(497), WIDTH'(1));
      runOp("mod1", WIDTH'(4), WIDTH'(13), WIDTH'(1), '0);

      for (int k = 0; k < 6; k++) begin
         b = {$urandom, $urandom, $urandom, $urandom};
         m = {$urandom, $urandom, $urandom, $urandom};
         if (k % 2 == 1) m = m >> $urandom_range(0, 120);
         e = WIDTH'($urandom_range(1, 4095));
         runOp("random", b, e, m, (m == 0) ? lastResult : refModExp(b, e, m));
      end

      // Writes during a run must not disturb the operands in use.
      applyStimulus(WIDTH'(4), WIDTH'(13), WIDTH'(497));
      busRead(3'd5, 0, st);
      checkOutput("busy status", WIDTH'(st), WIDTH'(2));
      busRead(3'd4, 0, st);
      checkOutput("result held", WIDTH'(st), WIDTH'(lastResult[DW-1:0]));
      busWrite(3'd0, 0, 32'h9);
      waitIrq(n);
      checkEnd("busy write", 1'b0, WIDTH'(445));
      readWide(3'd0, v);
      checkOutput("base unchanged", v, WIDTH'(4));

      applyStimulus(WIDTH'(7), WIDTH'(256), WIDTH'(13));
      repeat (40) @(negedge clk);
      busWrite(3'd3, 0, 32'h6);
      busRead(3'd5, 0, st);
      checkOutput("abort status", WIDTH'(st), WIDTH'(4));
      checkOutput("abort irq", WIDTH'(irq), '0);
      readWide(3'd4, v);
      checkOutput("abort result", v, lastResult);

      runOp("rerun", WIDTH'(7), WIDTH'(256), WIDTH'(13), WIDTH'(9));
      checkOutput("rerun irq", WIDTH'(irq), WIDTH'(1));
      busWrite(3'd5, 0, 32'h1);
      checkOutput("irq cleared", WIDTH'(irq), '0);
      busRead(3'd5, 0, st);
      checkOutput("done cleared", WIDTH'(st), '0);

      busWrite(3'd3, 0, 32'h7);
      busRead(3'd5, 0, st);
      checkOutput("abort beats start", WIDTH'(st), '0);

      applyStimulus(WIDTH'(5), WIDTH'(117), WIDTH'(19));
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrun reset ack", WIDTH'(ack), '0);
      rst_n = 1'b1;
      busRead(3'd5, 0, st);
      checkOutput("midrun reset status", WIDTH'(st), '0);
      busRead(3'd3, 0, st);
      checkOutput("midrun reset ctrl", WIDTH'(st), '0);
      readWide(3'd4, v);
      checkOutput("midrun reset result", v, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
